wheel_speed_ctrl: RTL and testbench
===================================

// Module: wheel_speed_ctrl
// PURPOSE
// Closed-loop speed controller for the two drive motors. Takes the step/direction
// outputs of the left and right quadrature decoders, counts signed encoder edges
// over a fixed gate window, and runs a shared proportional update on each wheel's
// signed duty. Drives one PWM/direction pair per H-bridge and sits between the
// navigation logic (signed speed targets) and the motor drivers.
// PARAMETERS
// WINDOW    50000  gate window length in clk cycles, must be >= 4
// CNT_W     12     signed width of edge counters, targets and speed outputs
// DUTY_W    8      PWM resolution; |duty| <= DUTY_MAX = 2**DUTY_W-1
// KP_SHIFT  2      proportional gain = 2**-KP_SHIFT, arithmetic right shift
// PORTS
// clk          in   1       system clock
// rst          in   1       synchronous, active-high reset
// enable       in   1       1 = closed loop running; 0 = motors off, loop idle
// enc_step_l   in   1       left decoder pulse; each rising edge is one encoder step
// enc_dir_l    in   1       left direction, sampled on the step edge; 1 = fwd (+1), 0 = rev (-1)
// enc_step_r   in   1       right decoder pulse, same rules as the left
// enc_dir_r    in   1       right direction, same rules as the left
// target_l     in   CNT_W   signed target, edges per window, left
// target_r     in   CNT_W   signed target, edges per window, right
// speed_l      out  CNT_W   signed measured edges, last completed window, left
// speed_r      out  CNT_W   signed measured edges, last completed window, right
// speed_valid  out  1       1-cycle strobe when speed_l and speed_r update
// pwm_l/pwm_r  out  1       PWM to the H-bridge enable pins
// dir_l/dir_r  out  1       motor direction: 1 = duty >= 0, 0 = duty < 0
// BEHAVIOUR
// - Reset: all outputs 0, both duties 0, edge counters and window counter 0, FSM IDLE.
// - Edge detect: one register stage per step input. A rising edge adds +1 or -1 to that
//   wheel's counter. The counter saturates at +/-(2**(CNT_W-1)-1) and does not wrap.
// - Window counter: runs 0..WINDOW-1 while enable=1. When the count is WINDOW-1 (cycle T):
//   counts plus any edge seen in cycle T are latched into speed_*. Speed outputs and the
//   speed_valid strobe are visible at T+1. Counters restart at 0; an edge detected in T+1
//   counts as 1 in the new window. Windows are back-to-back with no dead cycles.
// - FSM: IDLE, WAIT, UPD_L, UPD_R. One adder/saturator is time-shared between the wheels.
//   IDLE  : enable=0. Duties forced 0, counters and window counter held at 0.
//           Moves to WAIT when enable=1.
//   WAIT  : moves to UPD_L at T+1 (the same cycle as speed_valid).
//   UPD_L : err = target_l - speed_l at CNT_W+1 bits, sign-extended.
//           duty_l <= sat(duty_l + (err >>> KP_SHIFT)), visible at T+2. Moves to UPD_R.
//   UPD_R : same calculation for the right wheel, duty_r visible at T+3. Moves to WAIT.
//   sat() : clamps to [-DUTY_MAX, +DUTY_MAX]; sum computed wide enough to avoid overflow.
// - Targets are sampled only in the wheel's own UPD cycle and may change at any time.
// - enable=0 in any state, including mid-update: next cycle is IDLE. Duties, pwm_* and
//   dir_* go to 0 and any pending update is dropped. speed_* keep their last values.
//   Re-enable restarts the window from count 0 with cleared counters.
// - PWM: a free-running DUTY_W-bit counter. pwm_x registered = (pwm_cnt < |duty_x|), so
//   high for |duty_x| of 2**DUTY_W cycles. duty 0 keeps pwm_x low; dir_x registered with it.
// - Simultaneous left and right edges are counted independently.
// TESTING
// 1 rst=1 for 3 clk with random inputs -> every output 0; after release with enable=0, pwm stays 0
// 2 WINDOW=100, enable=1, 10 fwd left edges, target_l=20 -> speed_l=10, speed_valid at T+1, duty_l=2 at T+2
// 3 8 rev right edges, target_r=0 -> speed_r=-8, duty_r=+2 at T+3, dir_r=1, pwm_r high 2 of 256 cycles
// 4 target_l=2047, no edges, 200 windows -> duty_l clamps at 255, pwm_l high 255 of 256, no wrap
// 5 3000 fwd edges in one window (CNT_W=12) -> speed_l=2047; one edge in cycle T goes to the old window
// 6 enable drops during UPD_L -> next cycle IDLE, duties 0, pwm 0; re-enable -> first strobe after WINDOW cycles

Source files
------------

// File: rtl/wheel_speed_ctrl.sv
// wheel_speed_ctrl: two-wheel closed-loop speed controller.
// Gated encoder edge counting, time-shared P update, PWM/dir drive.
module wheel_speed_ctrl #(
    parameter int WINDOW   = 50000,
    parameter int CNT_W    = 12,
    parameter int DUTY_W   = 8,
    parameter int KP_SHIFT = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic                    enc_step_l,
    input  logic                    enc_dir_l,
    input  logic                    enc_step_r,
    input  logic                    enc_dir_r,
    input  logic signed [CNT_W-1:0] target_l,
    input  logic signed [CNT_W-1:0] target_r,
    output logic signed [CNT_W-1:0] speed_l,
    output logic signed [CNT_W-1:0] speed_r,
    output logic                    speed_valid,
    output logic                    pwm_l,
    output logic                    pwm_r,
    output logic                    dir_l,
    output logic                    dir_r
);

    localparam int WC_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    // Sum width covers the widest of error and duty plus carry headroom.
    localparam int SW = ((CNT_W > DUTY_W) ? CNT_W : DUTY_W) + 3;

    localparam logic signed [CNT_W-1:0] CMAX = {1'b0, {(CNT_W-1){1'b1}}};
    localparam logic signed [CNT_W-1:0] CMIN = -CMAX;
    localparam logic signed [CNT_W-1:0] ONE  = CNT_W'(1);
    localparam logic signed [SW-1:0]    DMAX = SW'((2**DUTY_W) - 1);
    localparam logic signed [SW-1:0]    DMIN = -DMAX;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        UPD_L,
        UPD_R
    } state_t;

    // Saturating +/-1 step of an edge counter.
    function automatic logic signed [CNT_W-1:0] step_cnt(
        input logic signed [CNT_W-1:0] c,
        input logic                    rise,
        input logic                    fwd
    );
        logic signed [CNT_W-1:0] r;
        r = c;
        if (rise && fwd && (c != CMAX)) begin
            r = c + ONE;
        end else if (rise && !fwd && (c != CMIN)) begin
            r = c - ONE;
        end
        return r;
    endfunction

    logic                    step_l_q;
    logic                    step_r_q;
    logic                    rise_l;
    logic                    rise_r;
    logic [WC_W-1:0]         wcnt;
    logic                    last;
    logic signed [CNT_W-1:0] cnt_l;
    logic signed [CNT_W-1:0] cnt_r;
    logic signed [CNT_W-1:0] nxt_l;
    logic signed [CNT_W-1:0] nxt_r;

    state_t                  state;
    logic signed [DUTY_W:0]  duty_l;
    logic signed [DUTY_W:0]  duty_r;
    logic signed [CNT_W-1:0] upd_tgt;
    logic signed [CNT_W-1:0] upd_spd;
    logic signed [DUTY_W:0]  upd_duty;
    logic signed [CNT_W:0]   err;
    logic signed [CNT_W:0]   corr;
    logic signed [SW-1:0]    corr_w;
    logic signed [SW-1:0]    duty_w;
    logic signed [SW-1:0]    sum;
    logic signed [DUTY_W:0]  upd_new;

    logic [DUTY_W-1:0]       pwm_cnt;
    logic [DUTY_W:0]         mag_l;
    logic [DUTY_W:0]         mag_r;

    assign rise_l = enc_step_l & ~step_l_q;
    assign rise_r = enc_step_r & ~step_r_q;
    assign last   = (wcnt == WC_W'(WINDOW - 1));
    assign nxt_l  = step_cnt(cnt_l, rise_l, enc_dir_l);
    assign nxt_r  = step_cnt(cnt_r, rise_r, enc_dir_r);

    // Step input history for rising-edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            step_l_q <= 1'b0;
            step_r_q <= 1'b0;
        end else begin
            step_l_q <= enc_step_l;
            step_r_q <= enc_step_r;
        end
    end

    // Gate window counter; held at zero while the loop is off.
    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            wcnt <= '0;
        end else if (last) begin
            wcnt <= '0;
        end else begin
            wcnt <= wcnt + WC_W'(1);
        end
    end

    // Edge counters; the edge in the last window cycle stays in that window.
    always_ff @(posedge clk) begin
        if (rst || !enable || last) begin
            cnt_l <= '0;
            cnt_r <= '0;
        end else begin
            cnt_l <= nxt_l;
            cnt_r <= nxt_r;
        end
    end

    // Latch the completed window and strobe it.
    always_ff @(posedge clk) begin
        if (rst) begin
            speed_l     <= '0;
            speed_r     <= '0;
            speed_valid <= 1'b0;
        end else begin
            speed_valid <= enable && last;
            if (enable && last) begin
                speed_l <= nxt_l;
                speed_r <= nxt_r;
            end
        end
    end

    // Shared error / gain / saturating accumulate, operands picked by state.
    always_comb begin
        upd_tgt  = target_l;
        upd_spd  = speed_l;
        upd_duty = duty_l;
        if (state == UPD_R) begin
            upd_tgt  = target_r;
            upd_spd  = speed_r;
            upd_duty = duty_r;
        end
        err    = {upd_tgt[CNT_W-1], upd_tgt} - {upd_spd[CNT_W-1], upd_spd};
        corr   = err >>> KP_SHIFT;
        corr_w = corr;
        duty_w = upd_duty;
        sum    = corr_w + duty_w;
        if (sum > DMAX) begin
            upd_new = DMAX[DUTY_W:0];
        end else if (sum < DMIN) begin
            upd_new = DMIN[DUTY_W:0];
        end else begin
            upd_new = sum[DUTY_W:0];
        end
    end

    // Update sequencer: one wheel per cycle after each speed strobe.
    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            state  <= IDLE;
            duty_l <= '0;
            duty_r <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (last) begin
                        state <= UPD_L;
                    end
                end
                UPD_L: begin
                    duty_l <= upd_new;
                    state  <= UPD_R;
                end
                UPD_R: begin
                    duty_r <= upd_new;
                    state  <= WAIT;
                end
            endcase
        end
    end

    // Free-running PWM ramp.
    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + DUTY_W'(1);
        end
    end

    always_comb begin
        mag_l = duty_l[DUTY_W] ? -duty_l : duty_l;
        mag_r = duty_r[DUTY_W] ? -duty_r : duty_r;
    end

    // Registered H-bridge drive; forced off while disabled.
    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            pwm_l <= 1'b0;
            pwm_r <= 1'b0;
            dir_l <= 1'b0;
            dir_r <= 1'b0;
        end else begin
            pwm_l <= ({1'b0, pwm_cnt} < mag_l);
            pwm_r <= ({1'b0, pwm_cnt} < mag_r);
            dir_l <= ~duty_l[DUTY_W];
            dir_r <= ~duty_r[DUTY_W];
        end
    end

endmodule

// File: tb/tb_wheel_speed_ctrl.sv
// tb_wheel_speed_ctrl: directed checks of windowing, update timing,
// saturation, PWM duty and enable handling.
module tb_wheel_speed_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic enable;
    logic enc_step_l;
    logic enc_dir_l;
    logic enc_step_r;
    logic enc_dir_r;
    logic signed [11:0] target_l;
    logic signed [11:0] target_r;
    logic signed [11:0] speed_l;
    logic signed [11:0] speed_r;
    logic speed_valid;
    logic pwm_l;
    logic pwm_r;
    logic dir_l;
    logic dir_r;

    logic s_enable;
    logic s_step_l;
    logic s_step_r;
    logic s_dir_l;
    logic s_dir_r;
    logic signed [11:0] s_target_l;
    logic signed [11:0] s_target_r;
    logic signed [11:0] s_speed_l;
    logic signed [11:0] s_speed_r;
    logic s_valid;
    logic s_pwm_l;
    logic s_pwm_r;
    logic s_dir_lo;
    logic s_dir_ro;

    wheel_speed_ctrl #(
        .WINDOW(100), .CNT_W(12), .DUTY_W(8), .KP_SHIFT(2)
    ) u_dut (
        .clk(clk), .rst(rst), .enable(enable),
        .enc_step_l(enc_step_l), .enc_dir_l(enc_dir_l),
        .enc_step_r(enc_step_r), .enc_dir_r(enc_dir_r),
        .target_l(target_l), .target_r(target_r),
        .speed_l(speed_l), .speed_r(speed_r),
        .speed_valid(speed_valid),
        .pwm_l(pwm_l), .pwm_r(pwm_r),
        .dir_l(dir_l), .dir_r(dir_r)
    );

    wheel_speed_ctrl #(
        .WINDOW(6100), .CNT_W(12), .DUTY_W(8), .KP_SHIFT(2)
    ) u_sat (
        .clk(clk), .rst(rst), .enable(s_enable),
        .enc_step_l(s_step_l), .enc_dir_l(s_dir_l),
        .enc_step_r(s_step_r), .enc_dir_r(s_dir_r),
        .target_l(s_target_l), .target_r(s_target_r),
        .speed_l(s_speed_l), .speed_r(s_speed_r),
        .speed_valid(s_valid),
        .pwm_l(s_pwm_l), .pwm_r(s_pwm_r),
        .dir_l(s_dir_lo), .dir_r(s_dir_ro)
    );

    int errs = 0;
    int checks = 0;

    task automatic chk(
        input string              tag,
        input logic signed [31:0] got,
        input logic signed [31:0] exp
    );
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int hi;
    int hi_l;
    int hi_r;
    int strobes;
    int early;
    int wrapped;

    initial begin
        rst = 1'b1;
        enable = 1'b0;
        enc_step_l = 1'b0;
        enc_dir_l = 1'b1;
        enc_step_r = 1'b0;
        enc_dir_r = 1'b0;
        target_l = '0;
        target_r = '0;
        s_enable = 1'b0;
        s_step_l = 1'b0;
        s_step_r = 1'b0;
        s_dir_l = 1'b1;
        s_dir_r = 1'b0;
        s_target_l = '0;
        s_target_r = '0;

        // reset with random inputs
        for (int i = 0; i < 3; i++) begin
            enable = 1'($urandom);
            enc_step_l = 1'($urandom);
            enc_dir_l = 1'($urandom);
            enc_step_r = 1'($urandom);
            enc_dir_r = 1'($urandom);
            target_l = 12'($urandom);
            target_r = 12'($urandom);
            tick();
        end
        chk("rst_speed_l", speed_l, 0);
        chk("rst_speed_r", speed_r, 0);
        chk("rst_valid", speed_valid, 0);
        chk("rst_pwm_l", pwm_l, 0);
        chk("rst_pwm_r", pwm_r, 0);
        chk("rst_dir_l", dir_l, 0);
        chk("rst_dir_r", dir_r, 0);

        enable = 1'b0;
        enc_step_l = 1'b0;
        enc_step_r = 1'b0;
        enc_dir_l = 1'b1;
        enc_dir_r = 1'b0;
        target_l = 12'sd20;
        target_r = 12'sd0;
        rst = 1'b0;
        hi = 0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (pwm_l || pwm_r || speed_valid) hi++;
        end
        chk("idle_quiet", hi, 0);

        hi_l = 0;
        hi_r = 0;
        strobes = 0;
        early = 0;
        wrapped = 0;
        for (int c = 1; c <= 20612; c++) begin
            enable = !(c >= 20501 && c <= 20510);
            enc_step_l = (c >= 82 && c <= 100 && (c % 2) == 0);
            enc_step_r = (c >= 3 && c <= 17 && (c % 2) == 1) ||
                         (c == 101) ||
                         (c >= 20403 && c <= 20407 && (c % 2) == 1);
            if (c == 460) target_l = 12'sd2047;
            tick();
            if (u_dut.duty_l < 0) wrapped = 1;
            if (c < 100 && speed_valid) early++;
            if (c >= 203 && c <= 458 && pwm_r) hi_r++;
            if (c >= 20202 && c <= 20457 && pwm_l) hi_l++;
            if (c >= 20511 && c <= 20609 && speed_valid) strobes++;
            case (c)
                100: begin
                    chk("early_strobe", early, 0);
                    chk("w1_valid", speed_valid, 1);
                    chk("w1_speed_l", speed_l, 10);
                    chk("w1_speed_r", speed_r, -8);
                end
                101: begin
                    chk("w1_valid_drop", speed_valid, 0);
                    chk("w1_duty_l", u_dut.duty_l, 2);
                end
                102: begin
                    chk("w1_duty_r", u_dut.duty_r, 2);
                    chk("w1_dir_l", dir_l, 1);
                end
                103: chk("w1_dir_r", dir_r, 1);
                200: begin
                    chk("w2_speed_l", speed_l, 0);
                    chk("w2_speed_r", speed_r, -1);
                end
                201: chk("w2_duty_l", u_dut.duty_l, 7);
                459: chk("pwm_r_hi", hi_r, 2);
                20460: begin
                    chk("clamp_duty_l", u_dut.duty_l, 255);
                    chk("pwm_l_hi", hi_l, 255);
                    chk("no_wrap", wrapped, 0);
                    chk("clamp_dir_l", dir_l, 1);
                end
                20500: chk("w205_speed_r", speed_r, -3);
                20501: begin
                    chk("off_pwm_l", pwm_l, 0);
                    chk("off_pwm_r", pwm_r, 0);
                    chk("off_dir_l", dir_l, 0);
                    chk("off_dir_r", dir_r, 0);
                    chk("off_duty_l", u_dut.duty_l, 0);
                    chk("off_duty_r", u_dut.duty_r, 0);
                end
                20510: begin
                    chk("off_keep_speed_r", speed_r, -3);
                    chk("off_pwm_l_hold", pwm_l, 0);
                end
                20610: begin
                    chk("reen_no_early", strobes, 0);
                    chk("reen_valid", speed_valid, 1);
                    chk("reen_speed_r", speed_r, 0);
                end
                default: ;
            endcase
        end

        // counter saturation, simultaneous opposite edges
        for (int c = 1; c <= 6103; c++) begin
            s_enable = 1'b1;
            s_step_l = (c <= 6000 && (c % 2) == 0);
            s_step_r = s_step_l;
            tick();
            case (c)
                6100: begin
                    chk("sat_valid", s_valid, 1);
                    chk("sat_speed_l", s_speed_l, 2047);
                    chk("sat_speed_r", s_speed_r, -2047);
                end
                6101: chk("sat_duty_l", u_sat.duty_l, -255);
                6102: begin
                    chk("sat_duty_r", u_sat.duty_r, 255);
                    chk("sat_dir_l", s_dir_lo, 0);
                end
                6103: chk("sat_dir_r", s_dir_ro, 1);
                default: ;
            endcase
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
